// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line-rate defaults and the
// parity helper used by both the receiver and the parametrised transmitter.
package uart_pkg;

  localparam int CLK_HZ          = 27_000_000;
  localparam int BAUD            = 115_200;
  localparam int DEFAULT_CLK_DIV = CLK_HZ / BAUD;
  localparam int DATA_BITS_MIN   = 5;
  localparam int DATA_BITS_MAX   = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Unused upper bits must be zero so the reduction sees only the real word.
  function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] data,
                                      input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops reset
// to RST_VAL so an idle-high line does not look like an edge after reset.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output, frame/break/overrun handling.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  // The bit counter has to reach CLK_DIV itself, hence the +1.
  localparam int            CW        = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] HALF      = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] FULL      = CW'(CLK_DIV);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  logic                 rxs;
  rx_state_e            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 fe_pend, fe_pend_n, fe_now, done;

`ifdef UART_RX_PARITY_EN
  logic pe_pend, pe_pend_n;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = ^PARITY_ODD;
`endif

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rx),
    .q   (rxs)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + ONE;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    fe_pend_n = fe_pend;
    fe_now    = fe_pend;
    done      = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_pend_n = pe_pend;
`endif
    case (state)
      IDLE: begin
        cnt_n = ONE;
        if (!rxs) begin
          state_n   = START;
          fe_pend_n = 1'b0;
`ifdef UART_RX_PARITY_EN
          pe_pend_n = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n     = ONE;
          bit_idx_n = '0;
          state_n   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          cnt_n   = ONE;
          shreg_n = {rxs, shreg[DATA_BITS-1:1]};
          if (bit_idx == LAST_DATA) begin
            bit_idx_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL) begin
          cnt_n     = ONE;
          pe_pend_n = rxs != parity_bit(DATA_BITS_MAX'(shreg), 1'(PARITY_ODD));
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == FULL) begin
          cnt_n     = ONE;
          fe_now    = fe_pend | ~rxs;
          fe_pend_n = fe_now;
          if (bit_idx == LAST_STOP) begin
            done    = 1'b1;
            // An all-zero word with a low stop bit is a break: wait for the line to recover.
            state_n = (fe_now && shreg == '0) ? WAIT_HIGH : IDLE;
          end else begin
            bit_idx_n = bit_idx + 4'd1;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_n = ONE;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      fe_pend   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_pend    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      fe_pend <= fe_pend_n;
      overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_pend <= pe_pend_n;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data   <= shreg;
          frame_err <= fe_now;
          rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err <= pe_pend;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: two instances (8N1 and 5-bit/2-stop),
// directed frames, monitors popping expected words on every accepted handshake.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0, rst1, line0, line1, ready0, ready1;
  logic [7:0] data0;
  logic [4:0] data1;
  logic       valid0, fe0, pe0, ovr0, busy0;
  logic       valid1, fe1, pe1, ovr1, busy1;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   ovr_cnt0 = 0;
  int   rise0_cyc = 0;
  int   rise1_cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut0 (
    .clk(clk), .rst(rst0), .uart_rx(line0), .rx_data(data0), .rx_valid(valid0),
    .rx_ready(ready0), .frame_err(fe0), .parity_err(pe0), .overrun(ovr0), .busy(busy0)
  );

  uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst1), .uart_rx(line1), .rx_data(data1), .rx_valid(valid1),
    .rx_ready(ready1), .frame_err(fe1), .parity_err(pe1), .overrun(ovr1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the 8-bit instance.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (ovr0) ovr_cnt0++;
      if (valid0 && !prev) rise0_cyc = cyc;
      prev = valid0;
      if (valid0 && ready0) begin
        if (q0.size() == 0) begin
          total_cnt++;
          $display("FAIL dut0 unexpected word: got 0x%0h expected none", data0);
        end else begin
          e = q0.pop_front();
          check("dut0 rx_data", 32'(data0), 32'(e.d));
          check("dut0 frame_err", 32'(fe0), 32'(e.fe));
          check("dut0 parity_err", 32'(pe0), 32'(e.pe));
        end
      end
    end
  end

  // Monitor for the 5-bit / 2-stop instance.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid1 && !prev) rise1_cyc = cyc;
      prev = valid1;
      if (valid1 && ready1) begin
        if (q1.size() == 0) begin
          total_cnt++;
          $display("FAIL dut1 unexpected word: got 0x%0h expected none", data1);
        end else begin
          e = q1.pop_front();
          check("dut1 rx_data", 32'(data1), 32'(e.d));
          check("dut1 frame_err", 32'(fe1), 32'(e.fe));
          check("dut1 parity_err", 32'(pe1), 32'(e.pe));
        end
      end
    end
  end

  // Frame bits LSB first: start, data, optional parity, stop bits.
  function automatic int build(input logic [8:0] d, input int db, input int sb, input bit odd,
                               input bit stop_low, input bit bad_par, output logic [15:0] f);
    int n = 0;
    f = '0;
    f[n] = 1'b0; n++;
    for (int i = 0; i < db; i++) begin f[n] = d[i]; n++; end
    if (PAR) begin f[n] = (^d) ^ odd ^ bad_par; n++; end
    for (int i = 0; i < sb; i++) begin f[n] = ~stop_low; n++; end
    return n;
  endfunction

  task automatic send(input bit ch, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (ch) line1 = f[i];
      else    line0 = f[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic frame0(input logic [8:0] d, input bit stop_low, input bit bad_par);
    logic [15:0] f;
    int n;
    n = build(d, 8, 1, 1'b1, stop_low, bad_par, f);
    send(1'b0, f, n);
    line0 = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] f;
    int n, start, base;
    rst0 = 1'b1; rst1 = 1'b1; line0 = 1'b1; line1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    idle(3);
    check("reset rx_data", 32'(data0), 32'h0);
    check("reset rx_valid", 32'(valid0), 32'h0);
    check("reset frame_err", 32'(fe0), 32'h0);
    check("reset parity_err", 32'(pe0), 32'h0);
    check("reset overrun", 32'(ovr0), 32'h0);
    check("reset busy", 32'(busy0), 32'h0);
    rst0 = 1'b0; rst1 = 1'b0;
    idle(5);

    // Clean 0xA5 with exact latency from the falling edge.
    q0.push_back('{d: 9'hA5, fe: 1'b0, pe: 1'b0});
    start = cyc;
    frame0(9'hA5, 1'b0, 1'b0);
    idle(20);
    check("dut0 latency", 32'(rise0_cyc - start), 32'(155 + DIV * int'(PAR)));

    // False start: 4-cycle glitch is rejected at the half-bit check.
    line0 = 1'b0;
    idle(4);
    check("glitch busy high", 32'(busy0), 32'h1);
    line0 = 1'b1;
    idle(8);
    check("glitch busy low", 32'(busy0), 32'h0);
    idle(20);

    // Low stop bit on a non-zero word.
    q0.push_back('{d: 9'h3C, fe: 1'b1, pe: 1'b0});
    frame0(9'h3C, 1'b1, 1'b0);
    idle(30);
    check("frame_err idle after", 32'(busy0), 32'h0);

    // Break: line low for the whole frame plus 40 cycles.
    q0.push_back('{d: 9'h00, fe: 1'b1, pe: PAR});
    line0 = 1'b0;
    idle(DIV * (10 + int'(PAR)) + 40);
    check("break wait_high busy", 32'(busy0), 32'h1);
    line0 = 1'b1;
    idle(5);
    check("break released", 32'(busy0), 32'h0);
    idle(20);

    // Overrun: consumer stalled while two words arrive.
    ready0 = 1'b0;
    q0.push_back('{d: 9'h11, fe: 1'b0, pe: 1'b0});
    frame0(9'h11, 1'b0, 1'b0);
    idle(10);
    check("stall rx_valid", 32'(valid0), 32'h1);
    base = ovr_cnt0;
    frame0(9'h22, 1'b0, 1'b0);
    idle(10);
    check("stall data held", 32'(data0), 32'h11);
    check("overrun pulses", 32'(ovr_cnt0 - base), 32'h1);
    ready0 = 1'b1;
    idle(1);
    check("valid drops after accept", 32'(valid0), 32'h0);
    idle(20);

    if (PAR) begin
      // Odd parity on 0x07: expected parity bit is 0.
      q0.push_back('{d: 9'h07, fe: 1'b0, pe: 1'b0});
      frame0(9'h07, 1'b0, 1'b0);
      idle(20);
      q0.push_back('{d: 9'h07, fe: 1'b0, pe: 1'b1});
      frame0(9'h07, 1'b0, 1'b1);
      idle(20);
    end

    // Reset in the middle of DATA on the 5-bit instance.
    n = build(9'h0A, 5, 2, 1'b0, 1'b0, 1'b0, f);
    send(1'b1, f, 4);
    rst1 = 1'b1;
    line1 = 1'b1;
    idle(2);
    check("midreset rx_valid", 32'(valid1), 32'h0);
    check("midreset busy", 32'(busy1), 32'h0);
    check("midreset rx_data", 32'(data1), 32'h0);
    rst1 = 1'b0;
    idle(20);
    check("after reset busy", 32'(busy1), 32'h0);
    q1.push_back('{d: 9'h15, fe: 1'b0, pe: 1'b0});
    n = build(9'h15, 5, 2, 1'b0, 1'b0, 1'b0, f);
    start = cyc;
    send(1'b1, f, n);
    idle(20);
    check("dut1 latency", 32'(rise1_cyc - start), 32'(2 + 8 + DIV * (7 + int'(PAR)) + 1));

    idle(10);
    check("dut0 scoreboard drained", 32'(q0.size()), 32'h0);
    check("dut1 scoreboard drained", 32'(q1.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
